mult_handshake_stage: RTL and testbench



---
 rtl/mult_handshake_stage.sv | 132 +++++++++++++
 tb/tb_mult_handshake_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_handshake_stage.sv
// Operand/result register stage around an external combinational multiplier.
// Holds operands for SETTLE_CYCLES clocks, then registers the product and flags under valid/ready.
module mult_handshake_stage #(
   parameter int MULTICAND_WID  = 32,
   parameter int MULTIPLIER_WID = 32,
   parameter int SETTLE_CYCLES  = 2,
   parameter int OP_CNT_WID     = 16
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic [MULTICAND_WID-1:0]                in_a,
   input  logic [MULTIPLIER_WID-1:0]               in_b,
   output logic [MULTICAND_WID-1:0]                mul_a,
   output logic [MULTIPLIER_WID-1:0]               mul_b,
   input  logic [MULTICAND_WID+MULTIPLIER_WID-1:0] mul_product,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic [MULTICAND_WID+MULTIPLIER_WID-1:0] out_product,
   output logic                                    out_zero,
   output logic                                    out_ovf,
   output logic                                    busy,
   output logic [OP_CNT_WID-1:0]                   op_count
);

   localparam int PROD_WID = MULTICAND_WID + MULTIPLIER_WID;
   localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic [OP_CNT_WID-1:0] OP_ONE = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_e;

   state_e                     state_q, state_d;
   logic [3:0]                 cnt_q, cnt_d;
   logic [MULTICAND_WID-1:0]   mul_a_q, mul_a_d;
   logic [MULTIPLIER_WID-1:0]  mul_b_q, mul_b_d;
   logic [PROD_WID-1:0]        prod_q, prod_d;
   logic                       zero_q, zero_d;
   logic                       ovf_q, ovf_d;
   logic                       valid_q, valid_d;
   logic [OP_CNT_WID-1:0]      op_cnt_q, op_cnt_d;
   logic                       accept;
   logic                       handoff;

   // Handshake: a transfer happens on a rising edge where valid and ready are both high;
   // out_* are held stable while out_valid is high and out_ready is low.
   assign in_ready = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
   assign accept   = in_valid && in_ready;
   assign handoff  = valid_q && out_ready;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mul_a_d  = mul_a_q;
      mul_b_d  = mul_b_q;
      prod_d   = prod_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      valid_d  = valid_q;
      op_cnt_d = op_cnt_q;

      // accept is only possible in IDLE or in DONE together with a handoff
      if (accept) begin
         mul_a_d = in_a;
         mul_b_d = in_b;
         cnt_d   = CNT_LOAD;
      end

      case (state_q)
         IDLE: begin
            if (accept) state_d = SETTLE;
         end
         SETTLE: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               prod_d  = mul_product;
               zero_d  = (mul_product == '0);
               ovf_d   = |mul_product[PROD_WID-1:MULTICAND_WID];
               valid_d = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (handoff) begin
               op_cnt_d = op_cnt_q + OP_ONE;
               valid_d  = 1'b0;
               state_d  = accept ? SETTLE : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         mul_a_q  <= '0;
         mul_b_q  <= '0;
         prod_q   <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
         op_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mul_a_q  <= mul_a_d;
         mul_b_q  <= mul_b_d;
         prod_q   <= prod_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
         op_cnt_q <= op_cnt_d;
      end
   end

   assign mul_a       = mul_a_q;
   assign mul_b       = mul_b_q;
   assign out_valid   = valid_q;
   assign out_product = prod_q;
   assign out_zero    = zero_q;
   assign out_ovf     = ovf_q;
   assign busy        = (state_q != IDLE);
   assign op_count    = op_cnt_q;

endmodule

// File: tb/tb_mult_handshake_stage.sv
// Directed bench: main stage (SETTLE_CYCLES=2) and a small-counter stage (SETTLE_CYCLES=1, OP_CNT_WID=2).
module tb_mult_handshake_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          tests = 0;
   int          fails = 0;

   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [31:0] in_a = '0, in_b = '0, mul_a, mul_b;
   logic [63:0] mul_product, out_product;
   logic        out_zero, out_ovf, busy;
   logic [15:0] op_count;

   logic        w_in_valid = 1'b0, w_in_ready, w_out_valid, w_out_ready = 1'b0;
   logic [31:0] w_in_a = '0, w_in_b = '0, w_mul_a, w_mul_b;
   logic [63:0] w_mul_product, w_out_product;
   logic        w_out_zero, w_out_ovf, w_busy;
   logic [1:0]  w_op_count;
   logic [1:0]  wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

   always #5 clk = ~clk;

   // Combinational multipliers standing in for the upstream array multiplier
   assign mul_product   = 64'(mul_a) * 64'(mul_b);
   assign w_mul_product = 64'(w_mul_a) * 64'(w_mul_b);

   mult_handshake_stage #(
      .MULTICAND_WID(32), .MULTIPLIER_WID(32), .SETTLE_CYCLES(2), .OP_CNT_WID(16)
   ) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b),
      .mul_product(mul_product), .out_valid(out_valid), .out_ready(out_ready),
      .out_product(out_product), .out_zero(out_zero), .out_ovf(out_ovf),
      .busy(busy), .op_count(op_count)
   );

   mult_handshake_stage #(
      .MULTICAND_WID(32), .MULTIPLIER_WID(32), .SETTLE_CYCLES(1), .OP_CNT_WID(2)
   ) u_wrap (
      .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
      .in_a(w_in_a), .in_b(w_in_b), .mul_a(w_mul_a), .mul_b(w_mul_b),
      .mul_product(w_mul_product), .out_valid(w_out_valid), .out_ready(w_out_ready),
      .out_product(w_out_product), .out_zero(w_out_zero), .out_ovf(w_out_ovf),
      .busy(w_busy), .op_count(w_op_count)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full op in IDLE with no backpressure; expects result two edges after accept
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_p, input logic exp_z, input logic exp_o,
                         input logic [15:0] exp_cnt);
      chk({tag, "_in_ready"}, in_ready, 1'b1);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      tick(1);
      in_valid = 1'b0;
      chk({tag, "_settle_valid"}, out_valid, 1'b0);
      chk({tag, "_busy"}, busy, 1'b1);
      tick(1);
      chk({tag, "_settle2_valid"}, out_valid, 1'b0);
      tick(1);
      chk({tag, "_valid"}, out_valid, 1'b1);
      chk({tag, "_product"}, out_product, exp_p);
      chk({tag, "_zero"}, out_zero, exp_z);
      chk({tag, "_ovf"}, out_ovf, exp_o);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, out_valid, 1'b0);
      chk({tag, "_idle"}, busy, 1'b0);
      chk({tag, "_op_count"}, op_count, exp_cnt);
   endtask

   initial begin
      // Reset state
      tick(1);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_product", out_product, 64'd0);
      chk("rst_mul_a", mul_a, 32'd0);
      chk("rst_op_count", op_count, 16'd0);
      #5 rst = 1'b0;
      #1;
      chk("rel_in_ready", in_ready, 1'b1);
      tick(1);

      // Reset mid-operation
      in_valid = 1'b1;
      in_a     = 32'd5;
      in_b     = 32'd7;
      tick(1);
      in_valid = 1'b0;
      chk("mid_busy_pre", busy, 1'b1);
      chk("mid_mul_a_pre", mul_a, 32'd5);
      #2 rst = 1'b1;
      #1;
      chk("mid_in_ready_rst", in_ready, 1'b0);
      chk("mid_out_valid", out_valid, 1'b0);
      chk("mid_product", out_product, 64'd0);
      chk("mid_busy", busy, 1'b0);
      chk("mid_mul_a", mul_a, 32'd0);
      chk("mid_op_count", op_count, 16'd0);
      tick(1);
      chk("mid_in_ready_hold", in_ready, 1'b0);
      #2 rst = 1'b0;
      #1;
      chk("mid_in_ready_rel", in_ready, 1'b1);
      tick(3);
      chk("mid_no_result", out_valid, 1'b0);
      chk("mid_op_count_after", op_count, 16'd0);

      // Basic, overflow, no-overflow, zero
      run_op("basic", 32'd3, 32'd4, 64'd12, 1'b0, 1'b0, 16'd1);
      run_op("ovf", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b1, 16'd2);
      run_op("noovf", 32'h0001_0000, 32'h0000_FFFF, 64'h0000_0000_FFFF_0000, 1'b0, 1'b0, 16'd3);
      run_op("zero", 32'd0, 32'h1234, 64'd0, 1'b1, 1'b0, 16'd4);

      // Backpressure with a waiting operand pair, then same-edge handoff and accept
      in_valid = 1'b1;
      in_a     = 32'd5;
      in_b     = 32'd7;
      tick(1);
      in_valid = 1'b0;
      tick(2);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_product", out_product, 64'd35);
      in_valid = 1'b1;
      in_a     = 32'd2;
      in_b     = 32'd9;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("bp_in_ready_%0d", i), in_ready, 1'b0);
         chk($sformatf("bp_hold_%0d", i), out_product, 64'd35);
         chk($sformatf("bp_valid_%0d", i), out_valid, 1'b1);
         chk($sformatf("bp_mul_a_%0d", i), mul_a, 32'd5);
         tick(1);
      end
      out_ready = 1'b1;
      #1;
      chk("b2b_in_ready", in_ready, 1'b1);
      tick(1);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("b2b_valid_drop", out_valid, 1'b0);
      chk("b2b_busy", busy, 1'b1);
      chk("b2b_mul_a", mul_a, 32'd2);
      chk("b2b_op_count", op_count, 16'd5);
      tick(1);
      chk("b2b_settle_valid", out_valid, 1'b0);
      tick(1);
      chk("b2b_valid", out_valid, 1'b1);
      chk("b2b_product", out_product, 64'd18);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      chk("b2b_op_count_end", op_count, 16'd6);
      chk("b2b_idle", busy, 1'b0);

      // Counter wrap on the 2-bit, single-settle instance: continuous streaming
      chk("wrap_start", w_op_count, 2'd0);
      w_out_ready = 1'b1;
      w_in_valid  = 1'b1;
      w_in_a      = 32'd6;
      w_in_b      = 32'd7;
      tick(1);
      chk("wrap_settle_valid", w_out_valid, 1'b0);
      tick(1);
      chk("wrap_valid", w_out_valid, 1'b1);
      chk("wrap_product", w_out_product, 64'd42);
      tick(1);
      chk("wrap_count_0", w_op_count, wrap_exp[0]);
      for (int i = 1; i < 5; i++) begin
         tick(2);
         chk($sformatf("wrap_count_%0d", i), w_op_count, wrap_exp[i]);
      end
      w_in_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
